// File: rtl/ahb_slave_arbiter.sv
// ahb_slave_arbiter
// Per-slave AHB arbiter. Grants one of MASTER_NUM requesting masters access
// to a single slave port and holds the grant for a whole transfer sequence.
// The policy is fixed at elaboration time:
//   ARB_MODE 0 = fixed priority (lowest index wins)
//   ARB_MODE 1 = round-robin
//   ARB_MODE 2 = dynamic priority, ties broken in round-robin order
// Re-arbitration happens only when the owner finishes its last beat or drops
// its request. A new winner is granted in the same edge, so a handover has no
// idle cycle.

module ahb_slave_arbiter #(
    parameter int  MASTER_NUM = 4,
    parameter int  PRIOR_BIT  = 2,
    parameter int  ARB_MODE   = 1,
    localparam int MIDX_W     = $clog2(MASTER_NUM)
) (
    input  logic                            hclk,
    input  logic                            hreset,
    input  logic [MASTER_NUM-1:0]           hreq,
    input  logic [MASTER_NUM-1:0]           hlast,
    input  logic                            hwait,
    input  logic [MASTER_NUM*PRIOR_BIT-1:0] hprior,
    output logic [MASTER_NUM-1:0]           hgrant,
    output logic                            hsel,
    output logic [MIDX_W-1:0]               hmaster
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t                 state;
    // Most recent winner. It is the starting point of the round-robin search.
    logic [MIDX_W-1:0]      rr_last;

    logic                   win_found;
    logic [MIDX_W-1:0]      win_idx;
    logic [PRIOR_BIT-1:0]   win_prior;
    logic                   release_owner;
    int                     cand;

    // Winner selection among the current requests, using the active policy
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        win_prior = '0;
        cand      = 0;
        if (ARB_MODE == 0) begin
            // Downward scan. The last hit, which is the lowest index, wins.
            for (int i = MASTER_NUM - 1; i >= 0; i--) begin
                if (hreq[i]) begin
                    win_found = 1'b1;
                    win_idx   = MIDX_W'(i);
                end
            end
        end else begin
            // Scan from rr_last+1 and wrap around, so the previous winner is
            // visited last. In dynamic mode a later candidate replaces the
            // current pick only with a strictly higher priority. A tie
            // therefore keeps the earlier candidate in round-robin order.
            for (int k = 1; k <= MASTER_NUM; k++) begin
                cand = (int'(rr_last) + k) % MASTER_NUM;
                if (hreq[cand] &&
                    (!win_found ||
                     (ARB_MODE == 2 &&
                      hprior[cand*PRIOR_BIT +: PRIOR_BIT] > win_prior))) begin
                    win_found = 1'b1;
                    win_idx   = MIDX_W'(cand);
                    win_prior = hprior[cand*PRIOR_BIT +: PRIOR_BIT];
                end
            end
        end
    end

    // The owner gives up the bus after its last beat completes, or when it
    // drops its request
    assign release_owner = (hlast[hmaster] && !hwait) || !hreq[hmaster];

    // FSM with registered grant, select and master index
    always_ff @(posedge hclk or posedge hreset) begin
        // NOTE: sequential state uses non-blocking assignments. Every flop then
        // samples values from before the edge, and there is no ordering race
        // with other always blocks.
        if (hreset) begin
            state   <= IDLE;
            hgrant  <= '0;
            hsel    <= 1'b0;
            hmaster <= '0;
            rr_last <= MIDX_W'(MASTER_NUM - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state   <= OWNED;
                        hgrant  <= MASTER_NUM'(1) << win_idx;
                        hsel    <= 1'b1;
                        hmaster <= win_idx;
                        rr_last <= win_idx;
                    end
                end
                OWNED: begin
                    if (release_owner) begin
                        if (win_found) begin
                            // Direct handover, with no idle cycle
                            hgrant  <= MASTER_NUM'(1) << win_idx;
                            hsel    <= 1'b1;
                            hmaster <= win_idx;
                            rr_last <= win_idx;
                        end else begin
                            state   <= IDLE;
                            hgrant  <= '0;
                            hsel    <= 1'b0;
                            hmaster <= '0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    hgrant  <= '0;
                    hsel    <= 1'b0;
                    hmaster <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// tb_ahb_slave_arbiter
// Runs three arbiters, one per ARB_MODE, from the same shared stimulus. For
// every clock edge the driver computes the expected response of each arbiter
// from a behavioural model and queues it. A monitor pops one entry each cycle,
// just after the rising edge, and compares.

module tb_ahb_slave_arbiter;

    typedef struct packed {
        logic [3:0] grant;
        logic       sel;
        logic [1:0] master;
    } resp_t;

    typedef resp_t [2:0] trio_t;

    logic       hclk;
    logic       hreset;
    logic [3:0] hreq;
    logic [3:0] hlast;
    logic       hwait;
    logic [7:0] hprior;

    logic [3:0] grant_o  [3];
    logic       sel_o    [3];
    logic [1:0] master_o [3];

    int passed_cnt;
    int total_cnt;
    int cycle_cnt;

    trio_t exp_q[$];

    // Model state, kept per mode. An owner of -1 means the slave is not owned.
    int m_owner [3];
    int m_rr    [3];

    for (genvar m = 0; m < 3; m++) begin : g_dut
        ahb_slave_arbiter #(
            .MASTER_NUM (4),
            .PRIOR_BIT  (2),
            .ARB_MODE   (m)
        ) u_dut (
            .hclk    (hclk),
            .hreset  (hreset),
            .hreq    (hreq),
            .hlast   (hlast),
            .hwait   (hwait),
            .hprior  (hprior),
            .hgrant  (grant_o[m]),
            .hsel    (sel_o[m]),
            .hmaster (master_o[m])
        );
    end

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic check(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) begin
            passed_cnt++;
        end else begin
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    function automatic int prio_of(input logic [7:0] pr, input int idx);
        return int'((pr >> (2 * idx)) & 8'h3);
    endfunction

    // Winner chosen by each policy, or -1 if nobody requests
    function automatic int pick(input int mode, input logic [3:0] req,
                                input logic [7:0] pr, input int rr);
        int maxp;
        int c;
        if (mode == 0) begin
            for (int i = 0; i < 4; i++) if (req[i]) return i;
            return -1;
        end
        maxp = -1;
        if (mode == 2) begin
            for (int i = 0; i < 4; i++)
                if (req[i] && prio_of(pr, i) > maxp) maxp = prio_of(pr, i);
        end
        for (int k = 1; k <= 4; k++) begin
            c = (rr + k) % 4;
            if (req[c] && (mode == 1 || prio_of(pr, c) == maxp)) return c;
        end
        return -1;
    endfunction

    // Advance the model by one edge under the current inputs, then queue the
    // outputs expected after that edge
    task automatic model_push();
        trio_t e;
        int    w;
        int    own;
        for (int m = 0; m < 3; m++) begin
            own = m_owner[m];
            if (hreset) begin
                m_owner[m] = -1;
                m_rr[m]    = 3;
            end else if (own < 0 ||
                         (hlast[own] && !hwait) || !hreq[own]) begin
                w = pick(m, hreq, hprior, m_rr[m]);
                m_owner[m] = w;
                if (w >= 0) m_rr[m] = w;
            end
            if (m_owner[m] >= 0) begin
                e[m].grant  = 4'(1 << m_owner[m]);
                e[m].sel    = 1'b1;
                e[m].master = 2'(m_owner[m]);
            end else begin
                e[m] = '0;
            end
        end
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus on the falling edge
    task automatic apply(input logic rst, input logic [3:0] req,
                         input logic [3:0] last, input logic wt,
                         input logic [7:0] pr);
        @(negedge hclk);
        hreset = rst;
        hreq   = req;
        hlast  = last;
        hwait  = wt;
        hprior = pr;
        model_push();
    endtask

    // Monitor: compare each DUT against the queued expectation just after the edge
    initial begin
        trio_t e;
        forever begin
            @(posedge hclk);
            #1;
            cycle_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int m = 0; m < 3; m++) begin
                    check($sformatf("mode%0d_cycle%0d", m, cycle_cnt),
                          int'({grant_o[m], sel_o[m], master_o[m]}),
                          int'(e[m]));
                end
            end
        end
    end

    initial begin
        passed_cnt = 0;
        total_cnt  = 0;
        cycle_cnt  = 0;
        for (int m = 0; m < 3; m++) begin
            m_owner[m] = -1;
            m_rr[m]    = 3;
        end
        hreset = 1'b1;
        hreq   = 4'b1111;
        hlast  = 4'b0000;
        hwait  = 1'b0;
        hprior = 8'h00;

        // Reset held while everyone requests. All outputs must stay 0.
        repeat (3) apply(1'b1, 4'b1111, 4'b0000, 1'b0, 8'h00);
        // Release reset. Master 0 is granted one edge later, in every mode.
        apply(1'b0, 4'b1111, 4'b0000, 1'b0, 8'h00);

        // Rotation: hlast is pulsed every third cycle while all four request
        for (int r = 0; r < 4; r++) begin
            apply(1'b0, 4'b1111, 4'b0000, 1'b0, 8'h00);
            apply(1'b0, 4'b1111, 4'b0000, 1'b0, 8'h00);
            apply(1'b0, 4'b1111, 4'b1111, 1'b0, 8'h00);
        end

        // Only master 2 requests, so every owner aborts and 2 is granted
        apply(1'b0, 4'b0100, 4'b0000, 1'b0, 8'h00);
        // Wait stall: hlast[2] is high but hwait holds the grant for 4 cycles
        repeat (4) apply(1'b0, 4'b0110, 4'b0100, 1'b1, 8'h00);
        apply(1'b0, 4'b0110, 4'b0100, 1'b0, 8'h00);
        // Master 1 now owns. It aborts with no other request, so the slave goes idle.
        apply(1'b0, 4'b0010, 4'b0000, 1'b0, 8'h00);
        apply(1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
        apply(1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);

        // Dynamic priority with a tie, starting from the post-reset rr_last of 3
        apply(1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00);
        apply(1'b0, 4'b1110, 4'b0000, 1'b0, 8'b11_11_01_00);
        apply(1'b0, 4'b1110, 4'b0000, 1'b0, 8'b11_11_01_00);
        apply(1'b0, 4'b1110, 4'b1111, 1'b0, 8'b11_11_01_00);
        apply(1'b0, 4'b1110, 4'b0000, 1'b0, 8'b11_11_01_00);

        // Fixed-priority starvation: master 0 keeps winning against master 1
        for (int r = 0; r < 4; r++) begin
            apply(1'b0, 4'b0011, 4'b0000, 1'b0, 8'h00);
            apply(1'b0, 4'b0011, 4'b1111, 1'b0, 8'h00);
        end

        // Reset asserted mid-transfer. It is sampled well away from any rising edge.
        @(negedge hclk);
        hreset = 1'b1;
        #1;
        for (int m = 0; m < 3; m++) begin
            check($sformatf("async_reset_mode%0d", m),
                  int'({grant_o[m], sel_o[m], master_o[m]}), 0);
        end
        model_push();
        apply(1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);

        // Random traffic
        for (int r = 0; r < 400; r++) begin
            apply(1'b0, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 1) ? 4'b1111 : 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                  8'($urandom_range(0, 255)));
        end

        repeat (2) @(negedge hclk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ahb_slave_arbiter.md
# ahb_slave_arbiter

Parametrised per-slave AHB arbiter that grants one of `MASTER_NUM` requesting masters access to a single slave port of the generated interconnect. It sits between the per-master address decoders (which raise `hreq`/`hlast` toward the slave) and the slave-side multiplexer (which consumes `hgrant`/`hmaster`). Fixed, round-robin and dynamic-priority modes are selectable at elaboration time. A grant is held for a whole transfer sequence and is re-arbitrated only at a transfer boundary.

## Interface
- `MASTER_NUM`, 4: number of requesting masters; legal range 2..16.
- `PRIOR_BIT`, 2: width of each master's dynamic priority field.
- `ARB_MODE`, 1: arbitration policy.
  - 0 = fixed priority, lowest index wins.
  - 1 = round-robin.
  - 2 = dynamic priority.
- `MIDX_W`, `$clog2(MASTER_NUM)`: width of `hmaster`; derived, do not override.
- `hclk` in 1: single clock, all state updates on the rising edge.
- `hreset` in 1: asynchronous, active-high reset.
- `hreq` in `MASTER_NUM`: per-master request to this slave.
- `hlast` in `MASTER_NUM`: per-master "current beat is last of sequence".
- `hwait` in 1: slave stall; high means the current beat is not completing.
- `hprior` in `MASTER_NUM*PRIOR_BIT`: packed priorities; master i uses bits `[i*PRIOR_BIT +: PRIOR_BIT]`. Used only when `ARB_MODE`=2.
- `hgrant` out `MASTER_NUM`: one-hot grant, registered.
- `hsel` out 1: slave selected; equals `|hgrant`, registered.
- `hmaster` out `MIDX_W`: index of the granted master, registered.

## Operation
- FSM has two states, IDLE and OWNED. State, `hgrant`, `hmaster` and `rr_last` are flops.
- IDLE:
  - If `|hreq`, pick a winner, load `hgrant`/`hmaster`, and go to OWNED.
  - Otherwise stay in IDLE with all outputs 0.
- OWNED: the owner is m = `hmaster`. The grant is released on an edge where either:
  - `hlast[m] && !hwait` (normal completion), or
  - `!hreq[m]` (owner aborts).
- On release:
  - Arbitrate among the current `hreq` in the same edge. The released owner participates only per the mode rules below.
  - If there is a winner, grant it directly with no idle cycle and stay in OWNED.
  - If there is no winner, go to IDLE and clear the outputs.
- Without a release, `hgrant` is held regardless of other requests. There is no preemption in any mode.
- Winner selection:
  - Mode 0: lowest set index of `hreq`.
  - Mode 1: first set index searching `rr_last+1, rr_last+2, …` modulo `MASTER_NUM`. `rr_last` updates to the winner on every grant. The released owner is therefore searched last.
  - Mode 2: largest `hprior` field among requesters. Ties go to the first tied index in round-robin order from `rr_last+1`. Priorities are sampled at the arbitration edge only.
- Invariants:
  - `hgrant` is one-hot or zero.
  - `hgrant[hmaster]==hsel`.
  - `hmaster` is 0 whenever `hsel`=0.

## Timing
- Reset, asynchronous, takes effect immediately:
  - `hgrant`=0, `hsel`=0, `hmaster`=0, state IDLE.
  - `rr_last`=`MASTER_NUM-1`, so master 0 is first after reset.
- Latency: `hreq` high at edge k in IDLE gives `hgrant`/`hsel` high after edge k (visible in cycle k+1). Minimum 1 cycle.
- Handover: on an edge with `hlast[m]`=1, `hwait`=0 and another request pending, `hgrant` switches directly from m to the new owner after that edge. `hsel` stays 1.
- `hlast[m]`=1 with `hwait`=1: grant is held; release happens on the first following edge with `hwait`=0 and `hlast[m]`=1.
- Simultaneous release and no other request: outputs go to 0 after that edge.
- `hlast` on non-owner lines and `hreq`/`hlast` of non-owners during OWNED are ignored.
- Reset asserted mid-transfer: outputs clear asynchronously, with no completion handshake. After deassertion, arbitration restarts from the post-reset state.

## Test plan
- Reset/idle: hold `hreset`=1 with `hreq`=4'b1111, then release. Required: outputs 0 during reset; one edge after release `hgrant`=4'b0001, `hmaster`=0.
- Mode 1 rotation: `hreq`=4'b1111 constant, `hlast[owner]` pulsed with `hwait`=0 every 3 cycles. Required grant sequence 0→1→2→3→0 with no idle cycle and `hsel` constantly 1.
- Wait-stall hold: owner 2 asserts `hlast[2]`=1 with `hwait`=1 for 4 cycles while `hreq[1]`=1. Required: `hgrant`=4'b0100 throughout; 4'b0010 one edge after `hwait` falls.
- Mode 2 priority/tie: `hreq`=4'b1110, `hprior`={3,3,1,0} (master3..0), `rr_last`=3. Required: grant master 2. After its release with the same inputs, grant master 3 (tie broken round-robin).
- Abort and empty release: owner 1 drops `hreq[1]` with no `hlast` and no other requests. Required: `hgrant`=0, `hsel`=0 after that edge; state IDLE.
- Mode 0 starvation check: `hreq`=4'b0011 constant, `hlast` pulsed each grant. Required: master 0 re-granted every time; master 1 never granted.
